multicycle_control_unit: RTL
============================

Name: multicycle_control_unit

Overview:
Multicycle MIPS-subset controller that replaces the single-cycle opcode decoder with a registered FSM. Each instruction is sequenced through fetch, decode, execute, memory and writeback steps. Every step drives the datapath enables, the mux selects and the ALU function code. Memory steps stall on a ready handshake, and undefined opcodes are flagged. The block sits between the instruction register and the shared-memory multicycle datapath.

Parameters:
FUNC_W, 6, ALU function-code width; must be >= 6; 6-bit codes are zero-extended into the upper bits.
MEM_HANDSHAKE, 1, 1: memory states wait for mem_ready; 0: memory completes in one cycle and mem_ready is ignored.
TRAP_ON_ILLEGAL, 1, 1: an illegal opcode enters HALT until reset; 0: it is treated as a NOP and the FSM returns to FETCH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
opcode  input  6  IR[31:26], valid from DECODE onward
funct  input  6  IR[5:0]
mem_ready  input  1  memory access complete this cycle
state  output  4  current state encoding, for debug
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU zero
iord  output  1  0: memory address = PC; 1: memory address = ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  IR load
reg_dst  output  1  1: write register = rd; 0: write register = rt
mem_to_reg  output  1  1: writeback data = MDR
reg_write  output  1  register file write
alu_src_a  output  1  0: A = PC; 1: A = register A
alu_src_b  output  2  0: B = reg B; 1: B = 4; 2: B = sign-extended imm; 3: B = sign-extended imm << 2
pc_source  output  2  0: ALU result; 1: ALUOut; 2: jump target
func_in  output  FUNC_W  ALU function (ADD=100000, SUB=100010)
illegal_op  output  1  sticky flag, set on an undefined opcode

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11, HALT=15.
- Outputs are a combinational Moore decode of state only. Every signal not listed for a state is 0, and func_in defaults to ADD.
- Reset (asynchronous, on rst_n low): state=FETCH and illegal_op=0, effective immediately; no waiting for a clock edge. Deasserting reset mid-instruction restarts at FETCH with no partial writes.
- FETCH: mem_read=1, alu_src_b=1, func_in=ADD.
  - ir_write and pc_write assert only in the completion cycle, i.e. the cycle where mem_ready=1 (or always when MEM_HANDSHAKE=0).
  - The FSM holds in FETCH while mem_ready=0.
  - Next state is DECODE.
- DECODE: alu_src_b=3 (branch target precompute). Next state by opcode:
  - 0x23 (lw) or 0x2B (sw): MEM_ADDR
  - 0x00 (R-type): R_EXEC
  - 0x04 (beq): BRANCH
  - 0x02 (j): JUMP
  - 0x08 (addi): I_EXEC
  - any other opcode: set illegal_op, then HALT if TRAP_ON_ILLEGAL=1, else FETCH
- MEM_ADDR: alu_src_a=1, alu_src_b=2. Next state is MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read=1, iord=1. Holds until mem_ready (subject to MEM_HANDSHAKE), then goes to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next state is FETCH.
- MEM_WRITE: mem_write=1, iord=1. Holds until mem_ready (subject to MEM_HANDSHAKE), then goes to FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=0, func_in=funct zero-extended. Next state is R_WB.
- R_WB: reg_write=1, reg_dst=1. Next state is FETCH.
- BRANCH: alu_src_a=1, func_in=SUB, pc_write_cond=1, pc_source=1. Next state is FETCH.
- JUMP: pc_write=1, pc_source=2. Next state is FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=2, func_in=ADD. Next state is I_WB.
- I_WB: reg_write=1, reg_dst=0. Next state is FETCH.
- HALT: all outputs are 0 except illegal_op. HALT is terminal until reset.
- Latency with mem_ready held at 1, counted as cycles from FETCH entry back to FETCH entry: lw=5, sw=4, R-type=4, addi=4, beq=3, j=3. Each cycle of mem_ready=0 adds one cycle.
- mem_ready asserted outside a memory state is ignored.
- illegal_op clears only on reset.

Test Plan:
- Reset, then lw (opcode 0x23) with mem_ready=1 -> states 0,1,2,3,4,0. mem_to_reg=1 and reg_write=1 only in state 4. Total 5 cycles.
- sw (opcode 0x2B) with mem_ready low for 3 cycles in MEM_WRITE -> state 5 held 4 cycles with mem_write=1 and iord=1. No reg_write at any point.
- R-type with funct=0x22 -> func_in=0x22 in R_EXEC. reg_dst=1 and reg_write=1 in R_WB. With FUNC_W=8: func_in=0x22 with the upper bits zero.
- beq and j -> pc_write_cond=1 with func_in=100010 in state 8. pc_write=1 with pc_source=2 in state 9. Each 3 cycles.
- Opcode 0x3F with TRAP_ON_ILLEGAL=1 -> HALT (state 15) and illegal_op=1, held for 20 cycles; rst_n low -> FETCH and illegal_op=0 without a clock edge. With TRAP_ON_ILLEGAL=0 -> back to FETCH with illegal_op=1.
- FETCH with mem_ready=0 for 2 cycles, MEM_HANDSHAKE=1 -> ir_write and pc_write stay 0 until the cycle with mem_ready=1. With MEM_HANDSHAKE=0 -> mem_ready ignored and FETCH lasts 1 cycle.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multicycle MIPS-subset controller sequencing fetch/decode/execute/memory/writeback.
module multicycle_control_unit #(
  parameter int FUNC_W          = 6,
  parameter bit MEM_HANDSHAKE   = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic              mem_ready,
  output logic [3:0]        state,
  output logic              pc_write,
  output logic              pc_write_cond,
  output logic              iord,
  output logic              mem_read,
  output logic              mem_write,
  output logic              ir_write,
  output logic              reg_dst,
  output logic              mem_to_reg,
  output logic              reg_write,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [1:0]        pc_source,
  output logic [FUNC_W-1:0] func_in,
  output logic              illegal_op
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_READ = 4'd3,
    MEM_WB = 4'd4, MEM_WRITE = 4'd5, R_EXEC = 4'd6, R_WB = 4'd7,
    BRANCH = 4'd8, JUMP = 4'd9, I_EXEC = 4'd10, I_WB = 4'd11, HALT = 4'd15
  } state_t;
  localparam logic [FUNC_W-1:0] ADD = FUNC_W'(6'h20);
  localparam logic [FUNC_W-1:0] SUB = FUNC_W'(6'h22);
  state_t state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   done;
  assign done       = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign state      = state_q;
  assign illegal_op = illegal_q;
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      FETCH:     state_d = done ? DECODE : FETCH;
      DECODE:
        case (opcode)
          6'h23, 6'h2B: state_d = MEM_ADDR;
          6'h00:        state_d = R_EXEC;
          6'h04:        state_d = BRANCH;
          6'h02:        state_d = JUMP;
          6'h08:        state_d = I_EXEC;
          default: begin
            illegal_d = 1'b1;
            state_d   = TRAP_ON_ILLEGAL ? HALT : FETCH;
          end
        endcase
      MEM_ADDR:  state_d = (opcode == 6'h2B) ? MEM_WRITE : MEM_READ;
      MEM_READ:  state_d = done ? MEM_WB : MEM_READ;
      MEM_WRITE: state_d = done ? FETCH : MEM_WRITE;
      R_EXEC:    state_d = R_WB;
      I_EXEC:    state_d = I_WB;
      HALT:      state_d = HALT;
      default:   state_d = FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end
  // Moore decode; FETCH additionally qualifies its loads with the memory handshake.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    pc_source     = 2'd0;
    func_in       = ADD;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = done;
        pc_write  = done;
      end
      DECODE:    alu_src_b = 2'd3;
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        func_in   = FUNC_W'(funct);
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        func_in       = SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'd1;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'd2;
      end
      I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      I_WB:      reg_write = 1'b1;
      HALT:      func_in = '0;
      default:   func_in = ADD;
    endcase
  end
endmodule
